// File: rtl/adma2_desc_fetch_if.sv
// rtl/adma2_desc_fetch_if.sv - memory read port and descriptor output bundle
interface adma2_desc_fetch_if #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DESC_ADDR_WIDTH = 32
);
    logic                       mem_req;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic                       mem_ack;
    logic [31:0]                mem_rdata;
    logic                       mem_err;
    logic                       desc_valid;
    logic                       desc_ready;
    logic [2:0]                 desc_act;
    logic                       desc_end;
    logic                       desc_int;
    logic [16:0]                desc_len;
    logic [DESC_ADDR_WIDTH-1:0] desc_addr;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata, mem_err,
        output desc_valid, desc_act, desc_end, desc_int, desc_len, desc_addr,
        input  desc_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata, mem_err,
        input  desc_valid, desc_act, desc_end, desc_int, desc_len, desc_addr,
        output desc_ready
    );
endinterface

// File: rtl/adma2_desc_fetch.sv
// rtl/adma2_desc_fetch.sv - ADMA2 descriptor fetch engine with link following and error detection
module adma2_desc_fetch #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DESC_ADDR_WIDTH = 32,
    parameter int LINK_LIMIT      = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] address,
    adma2_desc_fetch_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            err_code,
    output logic [ADDR_WIDTH-1:0] err_addr
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    localparam logic [2:0] E_INVALID = 3'b001;
    localparam logic [2:0] E_ALIGN   = 3'b010;
    localparam logic [2:0] E_BUS     = 3'b011;
    localparam logic [2:0] E_LINK    = 3'b100;

    localparam logic [2:0] ACT_NOP  = 3'b000;
    localparam logic [2:0] ACT_LINK = 3'b110;

    localparam int                    BEATS     = (DESC_ADDR_WIDTH == 64) ? 4 : 2;
    localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(BEATS * 4);
    localparam logic [1:0]            LAST_BEAT = 2'(BEATS - 1);
    localparam int                    CW        = $clog2(LINK_LIMIT + 1);
    localparam logic [CW-1:0]         LINK_MAX  = CW'(LINK_LIMIT - 1);

    logic [2:0]                 state;
    logic [ADDR_WIDTH-1:0]      ptr;
    logic [1:0]                 beat;
    logic [CW-1:0]              link_cnt;
    logic [31:0]                w0, w1, w2;
    logic [2:0]                 act;
    logic [DESC_ADDR_WIDTH-1:0] data_addr;
    logic [ADDR_WIDTH-1:0]      link_ptr;
    logic                       chain;
    logic                       unused_attr;

    // Truncating {w2,w1} keeps only w1 for 8-byte descriptors.
    assign act         = w0[5:3];
    assign data_addr   = DESC_ADDR_WIDTH'({w2, w1});
    assign link_ptr    = ADDR_WIDTH'(data_addr);
    assign chain       = (act == ACT_LINK) || (act == ACT_NOP && !w0[1]);
    assign unused_attr = ^w0[15:6];
    assign busy        = (state == S_FETCH) || (state == S_DECODE) || (state == S_PRESENT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= S_IDLE;
            ptr            <= '0;
            beat           <= '0;
            link_cnt       <= '0;
            w0             <= '0;
            w1             <= '0;
            w2             <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_code       <= '0;
            err_addr       <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.desc_valid <= 1'b0;
            bus.desc_act   <= '0;
            bus.desc_end   <= 1'b0;
            bus.desc_int   <= 1'b0;
            bus.desc_len   <= '0;
            bus.desc_addr  <= '0;
        end else if (stop) begin
            state          <= S_IDLE;
            bus.mem_req    <= 1'b0;
            bus.desc_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= '0;
                        ptr      <= address;
                        link_cnt <= '0;
                        if (address[2:0] != 3'd0) begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= E_ALIGN;
                            err_addr <= address;
                        end else begin
                            state        <= S_FETCH;
                            beat         <= '0;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= address;
                        end
                    end
                end
                S_FETCH: begin
                    if (bus.mem_req && bus.mem_ack) begin
                        if (bus.mem_err) begin
                            state       <= S_ERROR;
                            err         <= 1'b1;
                            err_code    <= E_BUS;
                            err_addr    <= ptr;
                            bus.mem_req <= 1'b0;
                        end else begin
                            case (beat)
                                2'd0:    w0 <= bus.mem_rdata;
                                2'd1:    w1 <= bus.mem_rdata;
                                2'd2:    w2 <= bus.mem_rdata;
                                default: ;
                            endcase
                            if (beat == LAST_BEAT) begin
                                state       <= S_DECODE;
                                bus.mem_req <= 1'b0;
                            end else begin
                                beat         <= beat + 2'd1;
                                bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(4);
                            end
                        end
                    end
                end
                S_DECODE: begin
                    if (!w0[0]) begin
                        state    <= S_ERROR;
                        err      <= 1'b1;
                        err_code <= E_INVALID;
                        err_addr <= ptr;
                    end else if (chain) begin
                        if (link_cnt == LINK_MAX) begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= E_LINK;
                            err_addr <= ptr;
                        end else if (act == ACT_LINK && link_ptr[2:0] != 3'd0) begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= E_ALIGN;
                            err_addr <= ptr;
                        end else begin
                            state        <= S_FETCH;
                            link_cnt     <= link_cnt + CW'(1);
                            beat         <= '0;
                            bus.mem_req  <= 1'b1;
                            ptr          <= (act == ACT_LINK) ? link_ptr : ptr + STRIDE;
                            bus.mem_addr <= (act == ACT_LINK) ? link_ptr : ptr + STRIDE;
                        end
                    end else begin
                        state          <= S_PRESENT;
                        bus.desc_valid <= 1'b1;
                        bus.desc_act   <= act;
                        bus.desc_end   <= w0[1];
                        bus.desc_int   <= w0[2];
                        bus.desc_len   <= (w0[31:16] == 16'd0) ? 17'h10000 : {1'b0, w0[31:16]};
                        bus.desc_addr  <= data_addr;
                    end
                end
                S_PRESENT: begin
                    if (bus.desc_ready) begin
                        bus.desc_valid <= 1'b0;
                        if (bus.desc_end) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= S_FETCH;
                            link_cnt     <= '0;
                            beat         <= '0;
                            bus.mem_req  <= 1'b1;
                            ptr          <= ptr + STRIDE;
                            bus.mem_addr <= ptr + STRIDE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adma2_desc_fetch.sv
// tb/tb_adma2_desc_fetch.sv - directed vector bench for adma2_desc_fetch in 32- and 64-bit modes
module tb_adma2_desc_fetch;
    logic        CLK = 1'b0;
    logic        RESET, start, start64, stop;
    logic [63:0] address;
    logic        busy32, done32, err32, busy64, done64, err64;
    logic [2:0]  code32, code64;
    logic [63:0] eaddr32, eaddr64;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    adma2_desc_fetch_if #(.ADDR_WIDTH(64), .DESC_ADDR_WIDTH(32)) b32 ();
    adma2_desc_fetch_if #(.ADDR_WIDTH(64), .DESC_ADDR_WIDTH(64)) b64 ();

    adma2_desc_fetch #(.ADDR_WIDTH(64), .DESC_ADDR_WIDTH(32), .LINK_LIMIT(16)) dut32 (
        .CLK(CLK), .RESET(RESET), .start(start), .stop(stop), .address(address), .bus(b32),
        .busy(busy32), .done(done32), .err(err32), .err_code(code32), .err_addr(eaddr32));

    adma2_desc_fetch #(.ADDR_WIDTH(64), .DESC_ADDR_WIDTH(64), .LINK_LIMIT(16)) dut64 (
        .CLK(CLK), .RESET(RESET), .start(start64), .stop(stop), .address(address), .bus(b64),
        .busy(busy64), .done(done64), .err(err64), .err_code(code64), .err_addr(eaddr64));

    logic [31:0] mem [bit [63:0]];
    logic [63:0] log32[$];
    logic [63:0] log64[$];
    bit          auto32 = 1'b1;
    bit          manual_ack = 1'b0;
    logic [63:0] err_at = '1;

    function automatic logic [31:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [63:0] logv(input int i);
        return (log32.size() > i) ? log32[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    // Memory for the 32-bit engine: ack after two request cycles, optional error address.
    initial begin
        int w;
        w = 0;
        b32.mem_ack = 1'b0; b32.mem_rdata = '0; b32.mem_err = 1'b0;
        forever begin
            @(negedge CLK);
            if (!auto32) begin
                b32.mem_ack = manual_ack; b32.mem_rdata = 32'h0; b32.mem_err = 1'b0; w = 0;
            end else if (b32.mem_ack) begin
                b32.mem_ack = 1'b0; b32.mem_err = 1'b0; w = 0;
            end else if (b32.mem_req) begin
                w++;
                if (w >= 2) begin
                    b32.mem_ack   = 1'b1;
                    b32.mem_rdata = rd(b32.mem_addr);
                    b32.mem_err   = (b32.mem_addr == err_at);
                    log32.push_back(b32.mem_addr);
                end
            end else w = 0;
        end
    end

    initial begin
        b64.mem_ack = 1'b0; b64.mem_rdata = '0; b64.mem_err = 1'b0;
        forever begin
            @(negedge CLK);
            if (b64.mem_ack) b64.mem_ack = 1'b0;
            else if (b64.mem_req) begin
                b64.mem_ack = 1'b1; b64.mem_rdata = rd(b64.mem_addr);
                log64.push_back(b64.mem_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        RESET = 1'b1; start = 1'b0; start64 = 1'b0; stop = 1'b0;
        b32.desc_ready = 1'b0; b64.desc_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic pulse_start(input logic [63:0] a);
        address = a; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_valid32(input int maxc);
        for (int i = 0; i < maxc && !b32.desc_valid; i++) @(negedge CLK);
    endtask

    task automatic wait_err32(input int maxc);
        for (int i = 0; i < maxc && !err32; i++) @(negedge CLK);
    endtask

    task automatic accept32();
        b32.desc_ready = 1'b1;
        @(negedge CLK);
        b32.desc_ready = 1'b0;
    endtask

    typedef struct {
        logic [63:0] base;
        logic [31:0] w0, w1;
        logic [2:0]  act;
        logic        e, i;
        logic [16:0] len;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{64'd64,                  32'h0200_0023, 32'h0000_1000, 3'b100, 1'b1, 1'b0, 17'd512,   32'h0000_1000};
        vecs[1] = '{64'd128,                 32'h0000_0023, 32'h0000_2000, 3'b100, 1'b1, 1'b0, 17'h10000, 32'h0000_2000};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_0027, 32'hDEAD_BEEF, 3'b100, 1'b1, 1'b1, 17'd65535, 32'hDEAD_BEEF};
        vecs[3] = '{64'h200,                 32'h0005_0003, 32'h0000_0040, 3'b000, 1'b1, 1'b0, 17'd5,     32'h0000_0040};

        address = '0;
        do_reset();
        chk("rst_mem_req", b32.mem_req, 0);
        chk("rst_desc_valid", b32.desc_valid, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_err", err32, 0);
        chk("rst_err_code", code32, 0);
        chk("rst_mem_addr", b32.mem_addr, 0);
        chk("rst_desc_len", b32.desc_len, 0);

        foreach (vecs[k]) begin
            mem[vecs[k].base] = vecs[k].w0;
            mem[vecs[k].base + 64'd4] = vecs[k].w1;
            log32.delete();
            pulse_start(vecs[k].base);
            chk("vec_busy", busy32, 1);
            wait_valid32(60);
            chk("vec_valid", b32.desc_valid, 1);
            chk("vec_act", b32.desc_act, vecs[k].act);
            chk("vec_end", b32.desc_end, vecs[k].e);
            chk("vec_int", b32.desc_int, vecs[k].i);
            chk("vec_len", b32.desc_len, vecs[k].len);
            chk("vec_addr", b32.desc_addr, vecs[k].addr);
            chk("vec_beat0", logv(0), vecs[k].base);
            chk("vec_beat1", logv(1), vecs[k].base + 64'd4);
            accept32();
            chk("vec_valid_drop", b32.desc_valid, 0);
            chk("vec_done", done32, 1);
            chk("vec_busy_end", busy32, 0);
        end

        // Link is followed internally and never presented.
        mem[64] = 32'h0000_0031; mem[68] = 32'h0000_0100;
        mem[256] = 32'h0000_0023; mem[260] = 32'h0000_2000;
        log32.delete();
        pulse_start(64);
        wait_valid32(100);
        chk("link_valid", b32.desc_valid, 1);
        chk("link_addr", b32.desc_addr, 32'h2000);
        chk("link_len", b32.desc_len, 17'h10000);
        chk("link_fetches", log32.size(), 4);
        chk("link_next_addr", logv(2), 256);
        accept32();
        chk("link_done", done32, 1);

        // Backpressure: fields hold, next descriptor not fetched until handshake.
        mem[64] = 32'h0200_0021; mem[68] = 32'h0000_1000;
        mem[72] = 32'h0200_0023; mem[76] = 32'h0000_3000;
        log32.delete();
        pulse_start(64);
        wait_valid32(60);
        repeat (5) begin
            @(negedge CLK);
            chk("bp_valid", b32.desc_valid, 1);
            chk("bp_addr", b32.desc_addr, 32'h1000);
            chk("bp_fetches", log32.size(), 2);
        end
        chk("bp_end", b32.desc_end, 0);
        accept32();
        chk("bp_valid_drop", b32.desc_valid, 0);
        wait_valid32(60);
        chk("bp_second_valid", b32.desc_valid, 1);
        chk("bp_second_addr", b32.desc_addr, 32'h3000);
        chk("bp_second_beat0", logv(2), 72);
        chk("bp_second_beat1", logv(3), 76);
        accept32();
        chk("bp_done", done32, 1);

        // Misaligned start: immediate error, no request.
        log32.delete();
        pulse_start(66);
        chk("mis_err", err32, 1);
        chk("mis_code", code32, 3'b010);
        chk("mis_eaddr", eaddr32, 66);
        repeat (3) @(negedge CLK);
        chk("mis_no_req", b32.mem_req, 0);
        chk("mis_no_fetch", log32.size(), 0);
        chk("mis_done_cleared", done32, 0);

        mem[64] = 32'h0200_0022; mem[68] = 32'h0000_1000;
        pulse_start(64);
        chk("inv_err_cleared", err32, 0);
        wait_err32(60);
        chk("inv_err", err32, 1);
        chk("inv_code", code32, 3'b001);
        chk("inv_eaddr", eaddr32, 64);
        chk("inv_no_valid", b32.desc_valid, 0);

        mem[64] = 32'h0200_0023; err_at = 64'd68;
        pulse_start(64);
        wait_err32(60);
        err_at = '1;
        chk("bus_err", err32, 1);
        chk("bus_code", code32, 3'b011);
        chk("bus_eaddr", eaddr32, 64);

        mem[64] = 32'h0000_0031; mem[68] = 32'h0000_0040;
        log32.delete();
        pulse_start(64);
        wait_err32(600);
        chk("lim_err", err32, 1);
        chk("lim_code", code32, 3'b100);
        chk("lim_eaddr", eaddr32, 64);
        chk("lim_fetches", log32.size(), 32);

        // stop while a request is outstanding; the late ack must be ignored.
        auto32 = 1'b0;
        pulse_start(64);
        repeat (2) @(negedge CLK);
        chk("stop_req_high", b32.mem_req, 1);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0; manual_ack = 1'b1;
        @(negedge CLK);
        manual_ack = 1'b0;
        repeat (3) @(negedge CLK);
        chk("stop_busy", busy32, 0);
        chk("stop_req", b32.mem_req, 0);
        chk("stop_valid", b32.desc_valid, 0);
        auto32 = 1'b1;
        mem[128] = 32'h0200_0023; mem[132] = 32'h0000_4000;
        log32.delete();
        pulse_start(128);
        wait_valid32(60);
        chk("restart_valid", b32.desc_valid, 1);
        chk("restart_addr", b32.desc_addr, 32'h4000);
        chk("restart_beat0", logv(0), 128);
        accept32();

        // RESET mid-fetch.
        pulse_start(128);
        @(negedge CLK);
        do_reset();
        chk("midrst_busy", busy32, 0);
        chk("midrst_req", b32.mem_req, 0);
        chk("midrst_done", done32, 0);

        // 64-bit descriptors: four beats, address from {w2,w1}.
        mem[64] = 32'h0010_0023; mem[68] = 32'h89AB_CDEF;
        mem[72] = 32'h0123_4567; mem[76] = 32'hFFFF_FFFF;
        log64.delete();
        address = 64; start64 = 1'b1;
        @(negedge CLK);
        start64 = 1'b0;
        for (int i = 0; i < 60 && !b64.desc_valid; i++) @(negedge CLK);
        chk("d64_valid", b64.desc_valid, 1);
        chk("d64_addr", b64.desc_addr, 64'h0123_4567_89AB_CDEF);
        chk("d64_len", b64.desc_len, 17'd16);
        chk("d64_fetches", log64.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("d64_beat", (log64.size() > i) ? log64[i] : 64'hDEAD, 64 + 4 * i);
        b64.desc_ready = 1'b1;
        @(negedge CLK);
        b64.desc_ready = 1'b0;
        chk("d64_done", done64, 1);
        chk("d64_busy", busy64, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
